// File: rtl/controlador_display.sv
// Sequencer for the 4-bit code encoder and 7-segment decoder pair: captures up to four
// debounced digit entries and time-multiplexes them through the encoder onto a 4-digit display.
module controlador_display #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_CYCLES     = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Input,
    input  logic       Ready,
    input  logic       Clear,
    input  logic [3:0] Encoded,
    output logic [3:0] EncInput,
    output logic       EncReady,
    output logic       EncReset,
    output logic [3:0] DispCode,
    output logic [3:0] Anode,
    output logic [2:0] Count,
    output logic       Full
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(SCAN_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, LATCH, HOLD} state_t;

    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              deb_level_q, deb_level_d, deb_prev_q, deb_prev_d;
    logic              capture_q, capture_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    state_t            state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        digit_q [4];
    logic [3:0]        digit_d [4];
    logic [2:0]        count_q, count_d;
    logic              full_q, full_d;
    logic [3:0]        enc_input_q, enc_input_d;
    logic [3:0]        disp_code_q, disp_code_d;
    logic [3:0]        anode_q, anode_d;
    logic              enc_ready_q, enc_ready_d;
    logic              enc_reset_q, enc_reset_d;

    // Ready conditioning: synchronize, require a run of disagreeing cycles, then pulse on the rising level
    always_comb begin
        sync1_d     = Ready;
        sync2_d     = sync1_q;
        deb_cnt_d   = '0;
        deb_level_d = deb_level_q;
        if (sync2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = ~deb_level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        deb_prev_d = deb_level_q;
        capture_d  = deb_level_q & ~deb_prev_q;
    end

    always_comb begin
        digit_d = digit_q;
        count_d = count_q;
        if (Clear) begin
            count_d = '0;
            for (int i = 0; i < 4; i++) digit_d[i] = '0;
        end else if (capture_q && count_q != 3'd4) begin
            digit_d[count_q[1:0]] = Input;
            count_d               = count_q + 3'd1;
        end
        full_d = (count_d == 3'd4);
    end

    // Scan FSM; the lit anode is decided when entering HOLD so a mid-slot capture shows on the next visit
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        hold_d      = hold_q;
        enc_input_d = enc_input_q;
        disp_code_d = disp_code_q;
        anode_d     = anode_q;
        enc_ready_d = enc_ready_q;
        enc_reset_d = enc_reset_q;
        if (Clear || count_q == 3'd0) begin
            state_d     = IDLE;
            anode_d     = 4'b1111;
            enc_ready_d = 1'b1;
            enc_reset_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = LOAD;
                    slot_d      = 2'd0;
                    enc_input_d = digit_q[0];
                    enc_ready_d = 1'b0;
                    enc_reset_d = 1'b1;
                    anode_d     = 4'b1111;
                end
                LOAD: state_d = LATCH;
                LATCH: begin
                    state_d     = HOLD;
                    hold_d      = '0;
                    disp_code_d = Encoded;
                    enc_ready_d = 1'b1;
                    enc_reset_d = 1'b0;
                    anode_d     = ({1'b0, slot_q} < count_q) ? ~(4'b0001 << slot_q) : 4'b1111;
                end
                HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d     = LOAD;
                        slot_d      = slot_q + 2'd1;
                        enc_input_d = digit_q[slot_q + 2'd1];
                        enc_ready_d = 1'b0;
                        enc_reset_d = 1'b1;
                        anode_d     = 4'b1111;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_level_q <= 1'b0;
            deb_prev_q  <= 1'b0;
            deb_cnt_q   <= '0;
            capture_q   <= 1'b0;
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            state_q     <= IDLE;
            slot_q      <= '0;
            hold_q      <= '0;
            enc_input_q <= '0;
            disp_code_q <= '0;
            anode_q     <= 4'b1111;
            enc_ready_q <= 1'b1;
            enc_reset_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_level_q <= deb_level_d;
            deb_prev_q  <= deb_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            capture_q   <= capture_d;
            digit_q     <= digit_d;
            count_q     <= count_d;
            full_q      <= full_d;
            state_q     <= state_d;
            slot_q      <= slot_d;
            hold_q      <= hold_d;
            enc_input_q <= enc_input_d;
            disp_code_q <= disp_code_d;
            anode_q     <= anode_d;
            enc_ready_q <= enc_ready_d;
            enc_reset_q <= enc_reset_d;
        end
    end

    assign EncInput = enc_input_q;
    assign EncReady = enc_ready_q;
    assign EncReset = enc_reset_q;
    assign DispCode = disp_code_q;
    assign Anode    = anode_q;
    assign Count    = count_q;
    assign Full     = full_q;

endmodule

// File: tb/tb_controlador_display.sv
// Scoreboard bench for controlador_display: stimulus pushes expected output events (with the
// cycle they must appear on) and two monitors pop and compare whenever the outputs change.
module tb_controlador_display;

    localparam int DEB    = 4;
    localparam int SCAN   = 8;
    localparam int PERIOD = SCAN + 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Input = 4'h0;
    logic       Ready = 1'b0;
    logic       Clear = 1'b0;
    logic [3:0] Encoded;
    logic [3:0] EncInput;
    logic       EncReady;
    logic       EncReset;
    logic [3:0] DispCode;
    logic [3:0] Anode;
    logic [2:0] Count;
    logic       Full;

    controlador_display #(.DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
        .Clock(Clock), .Reset(Reset), .Input(Input), .Ready(Ready), .Clear(Clear),
        .Encoded(Encoded), .EncInput(EncInput), .EncReady(EncReady), .EncReset(EncReset),
        .DispCode(DispCode), .Anode(Anode), .Count(Count), .Full(Full)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [3:0] enc_map(input logic [3:0] d);
        case (d)
            4'h3:    return 4'h5;
            4'h7:    return 4'hA;
            default: return ~d;
        endcase
    endfunction

    assign Encoded = (!EncReady && EncReset) ? enc_map(EncInput) : 4'h0;

    typedef struct {int cyc; logic [2:0] count; logic full;} cnt_ev_t;
    typedef struct {int cyc; logic [3:0] anode; logic [3:0] disp; logic er; logic rs;} disp_ev_t;

    cnt_ev_t  cnt_sb[$];
    disp_ev_t disp_sb[$];
    int       compared   = 0;
    int       mismatched = 0;
    bit       disp_chk   = 1'b0;
    logic [3:0] last_cnt  = 4'h0;
    logic [9:0] last_disp = 10'h0;

    logic [3:0] exp_digit [4];
    int         exp_count  = 0;
    int         scan_start = 0;

    // Count/Full monitor: every change must match the head of the count scoreboard
    always @(negedge Clock) begin
        cnt_ev_t e;
        if ({Count, Full} != last_cnt) begin
            compared++;
            if (cnt_sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL count_event: unexpected Count=%0d Full=%0d at cycle %0d", Count, Full, cyc);
            end else begin
                e = cnt_sb.pop_front();
                if (e.cyc != cyc || e.count !== Count || e.full !== Full) begin
                    mismatched++;
                    $display("[TB] FAIL count_event: got cycle=%0d Count=%0d Full=%0d, expected cycle=%0d Count=%0d Full=%0d",
                             cyc, Count, Full, e.cyc, e.count, e.full);
                end
            end
        end
        last_cnt = {Count, Full};
    end

    // Display monitor: changes of {Anode, DispCode, EncReady, EncReset} inside checking windows
    always @(negedge Clock) begin
        disp_ev_t e;
        if (disp_chk && {Anode, DispCode, EncReady, EncReset} != last_disp) begin
            compared++;
            if (disp_sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL disp_event: unexpected Anode=%b DispCode=%h EncReady=%b EncReset=%b at cycle %0d",
                         Anode, DispCode, EncReady, EncReset, cyc);
            end else begin
                e = disp_sb.pop_front();
                if (e.cyc != cyc || e.anode !== Anode || e.disp !== DispCode || e.er !== EncReady || e.rs !== EncReset) begin
                    mismatched++;
                    $display("[TB] FAIL disp_event: got cycle=%0d Anode=%b DispCode=%h ER=%b RS=%b, expected cycle=%0d Anode=%b DispCode=%h ER=%b RS=%b",
                             cyc, Anode, DispCode, EncReady, EncReset, e.cyc, e.anode, e.disp, e.er, e.rs);
                end
            end
        end
        last_disp = {Anode, DispCode, EncReady, EncReset};
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge Clock);
    endtask

    task automatic push_cnt(input int c, input int count, input logic full);
        cnt_ev_t e;
        e.cyc = c; e.count = 3'(count); e.full = full;
        cnt_sb.push_back(e);
    endtask

    task automatic push_disp(input int c, input logic [3:0] a, input logic [3:0] d, input logic er, input logic rs);
        disp_ev_t e;
        e.cyc = c; e.anode = a; e.disp = d; e.er = er; e.rs = rs;
        disp_sb.push_back(e);
    endtask

    task automatic clear_model();
        exp_count = 0;
        for (int i = 0; i < 4; i++) exp_digit[i] = 4'h0;
    endtask

    // Expected LOAD/HOLD entry events of the running scan that fall inside (from_cyc, to_cyc]
    task automatic push_frames(input int from_cyc, input int to_cyc);
        int l_cyc, h_cyc, k;
        logic [3:0] a;
        for (int n = 0; scan_start + 1 + PERIOD * n <= to_cyc; n++) begin
            k     = n % 4;
            l_cyc = scan_start + 1 + PERIOD * n;
            h_cyc = l_cyc + 2;
            if (l_cyc > from_cyc)
                push_disp(l_cyc, 4'hF, (n == 0) ? 4'h0 : enc_map(exp_digit[(n + 3) % 4]), 1'b0, 1'b1);
            a = (k < exp_count) ? ~(4'b0001 << k) : 4'hF;
            if (h_cyc > from_cyc && h_cyc <= to_cyc)
                push_disp(h_cyc, a, enc_map(exp_digit[k]), 1'b1, 1'b0);
        end
    endtask

    task automatic apply_press(input logic [3:0] d);
        int p;
        p     = cyc;
        Input = d;
        Ready = 1'b1;
        if (exp_count < 4) begin
            exp_digit[exp_count] = d;
            exp_count++;
            if (exp_count == 1) scan_start = p + 8;
            push_cnt(p + 8, exp_count, exp_count == 4);
        end
        wait_cycles(10);
        Ready = 1'b0;
        wait_cycles(12);
    endtask

    task automatic apply_press_with_clear(input logic [3:0] d);
        int p;
        p     = cyc;
        Input = d;
        Ready = 1'b1;
        if (exp_count != 0) push_cnt(p + 8, 0, 1'b0);
        clear_model();
        wait_cycles(7);
        Clear = 1'b1;
        wait_cycles(1);
        Clear = 1'b0;
        wait_cycles(2);
        Ready = 1'b0;
        wait_cycles(12);
    endtask

    task automatic apply_clear();
        if (exp_count != 0) push_cnt(cyc + 1, 0, 1'b0);
        clear_model();
        Clear = 1'b1;
        wait_cycles(1);
        Clear = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [3:0] got, input logic [3:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic check_idle();
        for (int i = 0; i < 3; i++) begin
            check_output("idle_anode", Anode, 4'hF);
            check_output("idle_enc_gate", {2'b00, EncReady, EncReset}, 4'b0010);
            wait_cycles(1);
        end
        check_output("count", {1'b0, Count}, 4'(exp_count));
        check_output("full", {3'b000, Full}, {3'b000, exp_count == 4});
    endtask

    task automatic check_queues_empty(input string name);
        compared++;
        if (cnt_sb.size() != 0 || disp_sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL %s: %0d count / %0d display events never seen, expected 0 / 0",
                     name, cnt_sb.size(), disp_sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int target, r0;
        clear_model();
        wait_cycles(3);
        Reset = 1'b0;
        wait_cycles(2);
        $display("[TB] reset state");
        check_idle();
        check_output("reset_dispcode", DispCode, 4'h0);
        check_output("reset_encinput", EncInput, 4'h0);

        $display("[TB] buffer {3,7}: capture latency and scan frame");
        apply_press(4'h3);
        apply_press(4'h7);
        target = scan_start + 4 * PERIOD + 5;
        wait_until(target);
        disp_chk = 1'b1;
        r0 = target + 4 * PERIOD;
        push_frames(target, r0);
        wait_until(r0);
        $display("[TB] reset during HOLD of slot 0");
        Reset = 1'b1;
        push_cnt(r0 + 1, 0, 1'b0);
        push_disp(r0 + 1, 4'hF, 4'h0, 1'b1, 1'b0);
        clear_model();
        wait_cycles(1);
        Reset = 1'b0;
        wait_cycles(15);
        disp_chk = 1'b0;
        check_queues_empty("reset_scan_events");
        check_idle();

        $display("[TB] bouncing Ready");
        for (int i = 0; i < 12; i++) begin
            Ready = (i % 2 == 0);
            wait_cycles(1);
        end
        Ready = 1'b0;
        wait_cycles(20);
        check_idle();

        $display("[TB] five presses, fifth ignored");
        for (int i = 1; i <= 5; i++) apply_press(4'(i));
        target = scan_start + 11 * PERIOD + 5;
        wait_until(target);
        disp_chk = 1'b1;
        push_frames(target, target + 4 * PERIOD);
        wait_until(target + 4 * PERIOD);
        disp_chk = 1'b0;
        check_queues_empty("full_scan_events");
        check_output("full_count", {1'b0, Count}, 4'd4);
        check_output("full_flag", {3'b000, Full}, 4'd1);

        $display("[TB] clear, then clear colliding with a capture");
        apply_clear();
        wait_cycles(2);
        check_idle();
        apply_press(4'h6);
        apply_press_with_clear(4'h8);
        check_idle();
        apply_press(4'h2);
        target = scan_start + 4 * PERIOD + 5;
        wait_until(target);
        disp_chk = 1'b1;
        push_frames(target, target + 4 * PERIOD);
        wait_until(target + 4 * PERIOD);
        disp_chk = 1'b0;
        check_queues_empty("final_scan_events");
        check_output("final_count", {1'b0, Count}, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
